// File: rtl/mux16_rr_arbiter.sv
// rtl/mux16_rr_arbiter.sv - round-robin arbiter and select sequencer for a shared 16:1 bit mux
// Optional feature macro: MUX16_ARB_BURST_LIMIT_EN (forces release after MAX_BURST grant cycles)
module mux16_rr_arbiter #(
  parameter int MAX_BURST = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic [15:0] in,
  output logic [15:0] gnt,
  output logic [3:0]  sel,
  output logic        valid,
  output logic        out
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

  logic [0:0]  state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  sel_q, sel_d;
  logic [15:0] gnt_q, gnt_d;

  logic [3:0]  search_start;
  logic [4:0]  pick;
  logic        burst_done;
  logic        hold;

  // First set request bit scanning start, start+1, ... mod 16; {found, index}.
  function automatic logic [4:0] rr_pick(input logic [3:0] start, input logic [15:0] r);
    logic [4:0] res;
    logic [3:0] idx;
    res = '0;
    for (int i = 15; i >= 0; i--) begin
      idx = start + i[3:0];
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

`ifdef MUX16_ARB_BURST_LIMIT_EN
  assign burst_done = (cnt_q == BURST_MAX);
`else
  assign burst_done = 1'b0;
`endif

  // While granting, searching from c+1 puts the current grantee last in line.
  assign search_start = (state_q == GRANT) ? sel_q + 4'd1 : ptr_q;
  assign pick         = rr_pick(search_start, req);
  assign hold         = (state_q == GRANT) && req[sel_q] && !burst_done;

  // Next-state: continue the current grant, hand over with no bubble, or fall idle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    if (hold) begin
`ifdef MUX16_ARB_BURST_LIMIT_EN
      cnt_d = cnt_q + 8'd1;
`else
      // Hold is unbounded here; saturate so the counter never wraps.
      cnt_d = (cnt_q == BURST_MAX) ? cnt_q : cnt_q + 8'd1;
`endif
    end else if (pick[4]) begin
      state_d = GRANT;
      sel_d   = pick[3:0];
      gnt_d   = 16'd1 << pick[3:0];
      cnt_d   = 8'd1;
      ptr_d   = pick[3:0] + 4'd1;
    end else if (state_q == GRANT) begin
      state_d = IDLE;
      sel_d   = 4'd0;
      gnt_d   = 16'd0;
      cnt_d   = 8'd0;
    end
  end

  // State registers with synchronous active-high reset; a reset drops any live grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 4'd0;
      cnt_q   <= 8'd0;
      sel_q   <= 4'd0;
      gnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt   = gnt_q;
  assign sel   = sel_q;
  assign valid = |gnt_q;
  assign out   = valid & in[sel_q];

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb/tb_mux16_rr_arbiter.sv - self-checking bench for mux16_rr_arbiter
module tb_mux16_rr_arbiter;

  localparam int MB = 4;
`ifdef MUX16_ARB_BURST_LIMIT_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] din;
  logic [15:0] gnt;
  logic [3:0]  sel;
  logic        valid;
  logic        out;

  int n_cmp;
  int n_fail;

  // Reference: current grantee (-1 = idle), search pointer, burst count.
  int m_g;
  int m_ptr;
  int m_cnt;

  mux16_rr_arbiter #(.MAX_BURST(MB)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .in   (din),
    .gnt  (gnt),
    .sel  (sel),
    .valid(valid),
    .out  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int first_from(input int start, input logic [15:0] r);
    for (int k = 0; k < 16; k++) begin
      if (r[(start + k) % 16]) return (start + k) % 16;
    end
    return -1;
  endfunction

  function automatic void model_step(input logic r_rst, input logic [15:0] r);
    int w;
    if (r_rst) begin
      m_g = -1; m_ptr = 0; m_cnt = 0;
      return;
    end
    if (m_g >= 0 && r[m_g] && !(BURST_EN && m_cnt == MB)) begin
      m_cnt = m_cnt + 1;
      return;
    end
    w = (m_g < 0) ? first_from(m_ptr, r) : first_from((m_g + 1) % 16, r);
    if (w >= 0) begin
      m_g = w; m_cnt = 1; m_ptr = (w + 1) % 16;
    end else begin
      m_g = -1; m_cnt = 0;
    end
  endfunction

  function automatic logic [21:0] exp_vec();
    logic [15:0] g;
    logic [3:0]  s;
    if (m_g < 0) return 22'd0;
    g = 16'd1 << m_g;
    s = 4'(m_g);
    return {g, s, 1'b1, din[m_g]};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(rst, req);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 16'hFFFF; din = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({gnt, sel, valid, out} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d: got gnt=%h sel=%0d valid=%b out=%b, want all zero", i, gnt, sel, valid, out);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 16'h0001 || {gnt, sel, valid, out} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_first_grant: got gnt=%h sel=%0d, want gnt=0001 sel=0", gnt, sel);
    end
  endtask

  task automatic test_wrap();
    rst = 1'b1; req = 16'h0000; tick(); rst = 1'b0;
    req = 16'h8000; tick();
    req = 16'h8001;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({gnt, sel, valid, out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL wrap_hold15: got gnt=%h sel=%0d, want %h", gnt, sel, exp_vec());
      end
    end
    req = 16'h0001; tick();
    n_cmp++;
    if (gnt !== 16'h0001 || valid !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_to0: got gnt=%h valid=%b, want gnt=0001 valid=1", gnt, valid);
    end
    req = 16'h8002; tick();
    n_cmp++;
    if (gnt !== 16'h0002 || sel !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_search_from1: got gnt=%h sel=%0d, want gnt=0002 sel=1", gnt, sel);
    end
  endtask

  task automatic test_burst();
    rst = 1'b1; req = 16'h0000; tick(); rst = 1'b0;
    req = 16'h0003; din = 16'h0001;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if ({gnt, sel, valid, out} !== exp_vec() || valid !== 1'b1) begin
        n_fail++;
        $display("FAIL burst_seq cyc%0d: got gnt=%h sel=%0d valid=%b, want %h", i, gnt, sel, valid, exp_vec());
      end
    end
  endtask

  task automatic test_datapath();
    rst = 1'b1; req = 16'h0000; tick(); rst = 1'b0;
    req = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      tick();
      din = 16'($urandom);
      din[5] = i[0];
      #1;
      n_cmp++;
      if (out !== din[5] || {gnt, sel, valid, out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL datapath cyc%0d: got out=%b sel=%0d, want out=%b sel=5", i, out, sel, din[5]);
      end
      din[6] = ~din[6];
      #1;
      n_cmp++;
      if (out !== din[5]) begin
        n_fail++;
        $display("FAIL datapath_in6 cyc%0d: got out=%b, want %b", i, out, din[5]);
      end
    end
    req = 16'h0000; tick();
    din = 16'hFFFF; #1;
    n_cmp++;
    if ({valid, out} !== 2'b00) begin
      n_fail++;
      $display("FAIL datapath_idle: got valid=%b out=%b, want 0 0", valid, out);
    end
  endtask

  task automatic test_sole();
    rst = 1'b1; req = 16'h0000; tick(); rst = 1'b0;
    req = 16'h0100;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if (gnt !== 16'h0100 || valid !== 1'b1 || sel !== 4'd8) begin
        n_fail++;
        $display("FAIL sole_regrant cyc%0d: got gnt=%h sel=%0d valid=%b, want 0100 8 1", i, gnt, sel, valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; req = 16'h0000; tick(); rst = 1'b0;
    req = 16'h0008; tick(); tick();
    req = 16'hFFF8; rst = 1'b1; tick();
    n_cmp++;
    if ({gnt, sel, valid, out} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got gnt=%h sel=%0d valid=%b out=%b, want zero", gnt, sel, valid, out);
    end
    rst = 1'b0; tick();
    n_cmp++;
    if (gnt !== 16'h0008 || {gnt, sel, valid, out} !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_mid_regrant: got gnt=%h sel=%0d, want gnt=0008 sel=3", gnt, sel);
    end
  endtask

  task automatic test_random();
    rst = 1'b1; req = 16'h0000; tick(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3, 0) == 0) req[$urandom_range(15, 0)] = ~req[$urandom_range(15, 0)];
      if ($urandom_range(3, 0) == 0) req[$urandom_range(15, 0)] = $urandom_range(1, 0) == 1;
      if ($urandom_range(40, 0) == 0) req = 16'h0000;
      rst = ($urandom_range(63, 0) == 0);
      tick();
      din = 16'($urandom);
      #1;
      n_cmp++;
      if ({gnt, sel, valid, out} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random cyc%0d: got gnt=%h sel=%0d valid=%b out=%b, want %h", i, gnt, sel, valid, out, exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    m_g = -1; m_ptr = 0; m_cnt = 0;
    rst = 1'b1; req = 16'h0000; din = 16'h0000;
    test_reset();
    test_wrap();
    test_burst();
    test_datapath();
    test_sole();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
